beats_upsizer: RTL
==================

Name: beats_upsizer

Overview:
- Width-converting stage that consumes narrow beats on a beats_if rx port and produces wide beats on a beats_if tx port.
- It packs RATIO consecutive input beats into one output beat. The first beat goes into the lowest lane.
- It sits directly upstream of wide consumers: memory write paths and wide FIFOs fed by 32-bit producers.
- It sustains one input beat per cycle and supports a flush that emits a partially filled word.

Parameters:
- IN_WIDTH, 32, width of the input beat data.
- RATIO, 4, number of input beats per output beat. Legal range is 2 to 16; elaborate-time assertion otherwise.
- OUT_WIDTH, IN_WIDTH*RATIO, derived. Must not be overridden.
- CNT_W, $clog2(RATIO+1), width of the lane counter and of out_lanes.

Ports:
- clk  input  1  sole clock; all state updates on the rising edge.
- rst  input  1  asynchronous reset, active-high.
- in  beats_if.rx  IN_WIDTH  narrow input beat stream (data, valid, ready).
- out  beats_if.tx  OUT_WIDTH  wide output beat stream (data, valid, ready).
- flush  input  1  single-cycle request to emit the current partial word.
- out_lanes  output  CNT_W  number of valid lanes in out.data. Equals RATIO for a full word; 1..RATIO-1 for a flushed word. Valid while out.valid.

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is asynchronous and active-high.
- Reset values, applied immediately on rst assertion:
  - out.valid=0, out.data=0, out_lanes=0.
  - Internal lane count cnt=0, accumulator acc=0, flush_pending=0.
  - in.ready=0 while rst is high.
- Handshakes:
  - A transfer occurs on a rising edge where valid&&ready.
  - out.data, out.valid and out_lanes are registered and held stable while out.valid&&!out.ready.
  - in.ready is combinational from registered state and out.ready. It never depends on in.valid.
- Packing:
  - An accepted input beat is written to acc lane cnt, bits [cnt*IN_WIDTH +: IN_WIDTH].
  - cnt then increments.
  - Lanes at or above cnt are zero in acc.
- Output slot: slot_free = !out.valid || out.ready.
- in.ready = !rst && !flush_pending && (cnt < RATIO-1 || slot_free).
  - Lanes 0..RATIO-2 are always accepted.
  - The completing lane needs the slot free or draining in that cycle.
- Word completion: when a beat is accepted into lane RATIO-1, on the same edge:
  - out.data <= acc with the new lane merged in.
  - out.valid <= 1, out_lanes <= RATIO.
  - cnt <= 0, acc <= 0.
  - Latency is 1 cycle from the last input beat to out.valid.
- Back-to-back operation: full throughput, with one output word every RATIO cycles under continuous valid/ready.
- Flush:
  - flush high sets flush_pending, unless the request is resolved in the same cycle.
  - A beat accepted in the flush cycle is included in the flushed word.
  - If that beat completes a full word, the normal full emission occurs and flush_pending clears with no extra word.
  - Pending flush with cnt==0: clear flush_pending next edge; no empty word is ever emitted.
  - Pending flush with cnt>0 and slot_free: out.data <= acc (upper lanes zero), out_lanes <= cnt, out.valid <= 1, cnt <= 0, acc <= 0, flush_pending <= 0.
  - Pending flush with cnt>0 and the slot occupied: wait. in.ready stays 0 while pending.
  - flush asserted while already pending is ignored (idempotent).
- Output drain: out.ready&&out.valid with no new word loaded gives out.valid <= 0. out.data retains its value; only out.valid is significant.
- Reset mid-word or mid-flush: all partial data is discarded; nothing is emitted after deassertion.
- Assertions for the bench:
  - out.data stable while out.valid&&!out.ready.
  - cnt <= RATIO-1.
  - out_lanes != 0 whenever out.valid.

Test Plan:
- Continuous stream: RATIO=4, in.data=1,2,3,4,5,6,7,8 on consecutive cycles, out.ready=1.
  - Expect out.data=0x00000004_00000003_00000002_00000001 with out_lanes=4 one cycle after beat 4.
  - Expect 0x8_7_6_5 next; in.ready is never deasserted.
- Backpressure: out.ready=0 after the first word.
  - Beats 5,6,7 are accepted; beat 8 stalls with in.ready=0.
  - Raise out.ready: the first word transfers and beat 8 is accepted in the same cycle.
  - The second word follows; out.data is stable throughout the stall.
- Partial flush: beats 0xA,0xB, then a flush pulse.
  - Expect out.data=0x00000000_00000000_0000000B_0000000A with out_lanes=2.
  - The next word starts at lane 0.
- Flush coincident with beat: the third beat 0xC is accepted in the flush cycle after 0xA,0xB → out_lanes=3, lane2=0xC.
- Flush coincident with the completing 4th beat → exactly one word with out_lanes=4 and no trailing empty word.
- Flush with cnt==0 → no output.
- Async reset after 3 beats, mid-cycle:
  - Outputs go to zero immediately with no clock edge.
  - After release, beats 0x11..0x14 give one word 0x14_13_12_11; the discarded beats do not appear.

Source files
------------

// File: rtl/beats_upsizer_if.sv
// Valid/ready beat stream. The tx side drives data/valid and the rx side drives ready.
interface beats_if #(
    parameter int WIDTH = 32
);
    logic [WIDTH-1:0] data;
    logic             valid;
    logic             ready;

    modport tx (output data, output valid, input ready);
    modport rx (input data, input valid, output ready);
endinterface

// File: rtl/beats_upsizer.sv
// Packs RATIO narrow beats into one wide beat, lane 0 first, and can flush
// a partially filled word. Output word, valid and lane count are registered.
module beats_upsizer #(
    parameter int  IN_WIDTH  = 32,
    parameter int  RATIO     = 4,
    localparam int OUT_WIDTH = IN_WIDTH * RATIO,
    localparam int CNT_W     = $clog2(RATIO + 1)
) (
    input  logic             clk,
    input  logic             rst,
    beats_if.rx              in,
    beats_if.tx              out,
    input  logic             flush,
    output logic [CNT_W-1:0] out_lanes
);

    if (RATIO < 2 || RATIO > 16) begin : g_ratio_check
        $error("beats_upsizer: RATIO must lie in 2..16");
    end

    localparam logic [CNT_W-1:0] LAST_LANE  = CNT_W'(RATIO - 1);
    localparam logic [CNT_W-1:0] FULL_LANES = CNT_W'(RATIO);

    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [OUT_WIDTH-1:0] acc_q, acc_d;
    logic                 flush_pending_q, flush_pending_d;
    logic                 out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
    logic [CNT_W-1:0]     out_lanes_q, out_lanes_d;

    logic [OUT_WIDTH-1:0] merged;
    logic                 slot_free;
    logic                 in_ready;
    logic                 accept;
    logic                 complete;

    // Only the lane that finishes a word needs the output slot; earlier lanes
    // land in the accumulator and can always be taken.
    assign slot_free = !out_valid_q || out.ready;
    assign in_ready  = !rst && !flush_pending_q && ((cnt_q < LAST_LANE) || slot_free);
    assign accept    = in.valid && in_ready;
    assign complete  = accept && (cnt_q == LAST_LANE);

    assign in.ready  = in_ready;
    assign out.valid = out_valid_q;
    assign out.data  = out_data_q;
    assign out_lanes = out_lanes_q;

    always_comb begin
        merged = acc_q;
        for (int l = 0; l < RATIO; l++) begin
            if (cnt_q == CNT_W'(l)) begin
                merged[l*IN_WIDTH +: IN_WIDTH] = in.data;
            end
        end
    end

    // A flush raised together with an accepted beat takes that beat along;
    // a flush whose beat completes the word is absorbed by the full emission.
    always_comb begin
        cnt_d           = cnt_q;
        acc_d           = acc_q;
        flush_pending_d = flush_pending_q;
        out_valid_d     = out_valid_q && !out.ready;
        out_data_d      = out_data_q;
        out_lanes_d     = out_lanes_q;

        if (complete) begin
            out_valid_d     = 1'b1;
            out_data_d      = merged;
            out_lanes_d     = FULL_LANES;
            cnt_d           = '0;
            acc_d           = '0;
            flush_pending_d = 1'b0;
        end else if (accept) begin
            acc_d = merged;
            cnt_d = cnt_q + 1'b1;
            if (flush) begin
                flush_pending_d = 1'b1;
            end
        end else if (flush_pending_q) begin
            if (cnt_q == '0) begin
                flush_pending_d = 1'b0;
            end else if (slot_free) begin
                out_valid_d     = 1'b1;
                out_data_d      = acc_q;
                out_lanes_d     = cnt_q;
                cnt_d           = '0;
                acc_d           = '0;
                flush_pending_d = 1'b0;
            end
        end else if (flush && (cnt_q != '0)) begin
            flush_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q           <= '0;
            acc_q           <= '0;
            flush_pending_q <= 1'b0;
            out_valid_q     <= 1'b0;
            out_data_q      <= '0;
            out_lanes_q     <= '0;
        end else begin
            cnt_q           <= cnt_d;
            acc_q           <= acc_d;
            flush_pending_q <= flush_pending_d;
            out_valid_q     <= out_valid_d;
            out_data_q      <= out_data_d;
            out_lanes_q     <= out_lanes_d;
        end
    end

    a_data_stable: assert property (@(posedge clk) disable iff (rst)
        (out_valid_q && !out.ready) |=> $stable(out_data_q));
    a_cnt_range: assert property (@(posedge clk) disable iff (rst)
        cnt_q <= LAST_LANE);
    a_lanes_nonzero: assert property (@(posedge clk) disable iff (rst)
        out_valid_q |-> (out_lanes_q != '0));

endmodule
